pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Second-generation hazard controller for the 5-stage RV32 pipeline (F/D/E/M/W).
- Merges branch flush and M/W operand forwarding with three new functions:
  - load-use stall detection;
  - a memory-wait FSM with a stall-cycle timeout;
  - saturating performance counters for stall cycles and branch flushes.
- Sits beside the pipeline registers and drives their stall/flush enables and the E-stage operand muxes.

Parameters:
- REG_ADDR_W, 5, register index width (32 architectural registers; x0 hard-wired zero).
- CNT_W, 32, width of the stall_count and flush_count performance counters.
- MEM_TIMEOUT, 255, maximum consecutive MEM_WAIT cycles before mem_timeout is raised (must be ≥1).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- branch_e  in  1  taken branch/jump resolved in E.
- rs1_d, rs2_d  in  REG_ADDR_W  source registers of the instruction in D.
- rs1_e, rs2_e  in  REG_ADDR_W  source registers of the instruction in E.
- rd_e  in  REG_ADDR_W  destination register in E.
- mem_read_e  in  1  instruction in E is a load.
- rd_m  in  REG_ADDR_W  destination register in M.
- reg_write_m  in  1  M writes the register file.
- rd_w  in  REG_ADDR_W  destination register in W.
- reg_write_w  in  1  W writes the register file.
- mem_req_m  in  1  data-memory access issued from M.
- mem_ready_m  in  1  data memory completes the access this cycle.
- stall_f, stall_d, stall_e, stall_m  out  1  hold the corresponding pipeline register.
- flush_d, flush_e, flush_w  out  1  load a bubble into the corresponding pipeline register.
- forward_a_e, forward_b_e  out  2  operand select: 00 register file, 01 from W, 10 from M.
- mem_timeout  out  1  sticky error flag.
- stall_count  out  CNT_W  cycles with stall_f asserted.
- flush_count  out  CNT_W  branch flush events.

Behaviour:
- Reset state (rst high, asynchronous):
  - FSM = RUN, timeout counter = 0, mem_timeout = 0, stall_count = 0, flush_count = 0.
  - All stall/flush outputs = 0; forward selects = 00.
- Forwarding (combinational, evaluated independently for A/rs1_e and B/rs2_e):
  - 10 if reg_write_m && rd_m != 0 && rd_m == rs.
  - Else 01 if reg_write_w && rd_w != 0 && rd_w == rs.
  - Else 00.
  - M has priority over W.
  - Forward selects stay valid during stalls.
- Load-use hazard: mem_read_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d).
- FSM states:
  - RUN: if mem_req_m && !mem_ready_m, go to MEM_WAIT. Otherwise stay in RUN.
  - MEM_WAIT: stay until mem_ready_m, then go to RUN on the next edge.
- Memory wait is decided combinationally from the RUN state, so it takes effect in the first cycle.
- Output priority per cycle, highest first:
  1. Memory wait (RUN with mem_req_m && !mem_ready_m, or MEM_WAIT with !mem_ready_m):
     - stall_f = stall_d = stall_e = stall_m = 1, flush_w = 1.
     - branch_e and load-use are ignored this cycle; E is frozen, so a pending branch_e persists and is handled after release.
  2. branch_e: flush_d = flush_e = 1, no stalls. Any load-use on the flushed D instruction is discarded.
  3. Load-use: stall_f = stall_d = 1 and flush_e = 1, for exactly one cycle. The load advances to M, the hazard clears, and the next cycle resolves through the M→E forward.
  4. Otherwise all stall/flush outputs = 0.
- mem_ready_m in the same cycle as mem_req_m: no stall, FSM stays in RUN, zero-latency access.
- Timeout:
  - The counter increments each cycle the FSM is in MEM_WAIT with mem_ready_m low, and clears on leaving MEM_WAIT.
  - When it reaches MEM_TIMEOUT, mem_timeout is set and stays set until rst.
  - The stall itself continues; there is no abort.
- stall_count: +1 on every cycle stall_f = 1 (load-use or memory wait). Saturates at all-ones.
- flush_count: +1 on every cycle case 2 applies. Saturates at all-ones.
- Counters are registered: an event on cycle n appears at the output on cycle n+1.
- Reset mid-MEM_WAIT: immediate return to RUN. All outputs drop to their reset values asynchronously.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10.
  - hz_state_t enum: RUN, MEM_WAIT.
- Sub-module fwd_select: one operand's forwarding comparator. Instantiated twice, for A and B.
- FSM, priority logic and counters stay in pipeline_hazard_ctrl.

Test Plan:
- Forwarding priority: rs1_e = 5, rd_m = 5 with reg_write_m = 1, rd_w = 5 with reg_write_w = 1 → forward_a_e = 10. Deassert reg_write_m → 01. Set rs1_e = 0 with both writers targeting x0 → 00.
- Load-use: mem_read_e = 1, rd_e = 7, rs2_d = 7 → one cycle of stall_f = stall_d = flush_e = 1. Next cycle, rd_m = 7 and rs2_e = 7 → forward_b_e = 10. stall_count = 1.
- Branch beats load-use: branch_e = 1 together with a load-use match → flush_d = flush_e = 1, stall_f = 0. flush_count increments to 1.
- Memory wait: mem_req_m = 1 with mem_ready_m low for 3 cycles, then high → all four stalls and flush_w high for 3 cycles, then RUN. stall_count += 3. branch_e held high throughout → flush_d/flush_e assert only on the release cycle.
- Timeout: MEM_TIMEOUT = 4, mem_ready_m held low for 6 cycles → mem_timeout rises on the 4th MEM_WAIT cycle and stays high after ready returns, until rst.
- Asynchronous reset asserted mid-MEM_WAIT between clock edges → outputs clear immediately, counters read 0, and the FSM is in RUN after reset release.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the RV32 5-stage hazard controller: operand-forward selects
// and the memory-wait FSM state encoding.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Forwarding comparator for one E-stage source operand; M has priority over W,
// and x0 is never forwarded.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic [REG_ADDR_W-1:0] i_rd_m,
    input  logic                  i_reg_write_m,
    input  logic [REG_ADDR_W-1:0] i_rd_w,
    input  logic                  i_reg_write_w,
    output fwd_sel_t              o_sel
);

    logic w_hit_m;
    logic w_hit_w;

    assign w_hit_m = i_reg_write_m && (i_rd_m != {REG_ADDR_W{1'b0}}) && (i_rd_m == i_rs);
    assign w_hit_w = i_reg_write_w && (i_rd_w != {REG_ADDR_W{1'b0}}) && (i_rd_w == i_rs);

    always_comb begin
        o_sel = FWD_RF;
        if (w_hit_m) begin
            o_sel = FWD_M;
        end else if (w_hit_w) begin
            o_sel = FWD_W;
        end else begin
            o_sel = FWD_RF;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: memory-wait FSM with timeout, branch flush, load-use stall,
// M/W operand forwarding and saturating stall/flush performance counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_branch_e,
    input  logic [REG_ADDR_W-1:0] i_rs1_d,
    input  logic [REG_ADDR_W-1:0] i_rs2_d,
    input  logic [REG_ADDR_W-1:0] i_rs1_e,
    input  logic [REG_ADDR_W-1:0] i_rs2_e,
    input  logic [REG_ADDR_W-1:0] i_rd_e,
    input  logic                  i_mem_read_e,
    input  logic [REG_ADDR_W-1:0] i_rd_m,
    input  logic                  i_reg_write_m,
    input  logic [REG_ADDR_W-1:0] i_rd_w,
    input  logic                  i_reg_write_w,
    input  logic                  i_mem_req_m,
    input  logic                  i_mem_ready_m,
    output logic                  o_stall_f,
    output logic                  o_stall_d,
    output logic                  o_stall_e,
    output logic                  o_stall_m,
    output logic                  o_flush_d,
    output logic                  o_flush_e,
    output logic                  o_flush_w,
    output logic [1:0]            o_forward_a_e,
    output logic [1:0]            o_forward_b_e,
    output logic                  o_mem_timeout,
    output logic [CNT_W-1:0]      o_stall_count,
    output logic [CNT_W-1:0]      o_flush_count
);

    localparam int                TCNT_W   = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(MEM_TIMEOUT);
    localparam logic [TCNT_W-1:0] TCNT_PRE = TCNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    hz_state_t         r_state;
    hz_state_t         w_state_next;
    logic [TCNT_W-1:0] r_tcnt;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_stall_count;
    logic [CNT_W-1:0]  r_flush_count;

    logic     w_mem_wait;
    logic     w_load_use;
    logic     w_wait_tick;
    logic     w_stall_fd;
    logic     w_stall_em;
    logic     w_flush_d;
    logic     w_flush_e;
    logic     w_flush_w;
    fwd_sel_t w_fwd_a;
    fwd_sel_t w_fwd_b;

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .i_rs          (i_rs1_e),
        .i_rd_m        (i_rd_m),
        .i_reg_write_m (i_reg_write_m),
        .i_rd_w        (i_rd_w),
        .i_reg_write_w (i_reg_write_w),
        .o_sel         (w_fwd_a)
    );

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .i_rs          (i_rs2_e),
        .i_rd_m        (i_rd_m),
        .i_reg_write_m (i_reg_write_m),
        .i_rd_w        (i_rd_w),
        .i_reg_write_w (i_reg_write_w),
        .o_sel         (w_fwd_b)
    );

    assign w_load_use  = i_mem_read_e && (i_rd_e != {REG_ADDR_W{1'b0}}) &&
                         ((i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d));
    assign w_wait_tick = (r_state == MEM_WAIT) && !i_mem_ready_m;

    // Next state plus stall/flush priority: memory wait, then branch, then load-use.
    always_comb begin
        w_state_next = r_state;
        w_mem_wait   = 1'b0;
        w_stall_fd   = 1'b0;
        w_stall_em   = 1'b0;
        w_flush_d    = 1'b0;
        w_flush_e    = 1'b0;
        w_flush_w    = 1'b0;

        case (r_state)
            RUN: begin
                w_mem_wait = i_mem_req_m && !i_mem_ready_m;
                if (w_mem_wait) begin
                    w_state_next = MEM_WAIT;
                end else begin
                    w_state_next = RUN;
                end
            end
            MEM_WAIT: begin
                w_mem_wait = !i_mem_ready_m;
                if (i_mem_ready_m) begin
                    w_state_next = RUN;
                end else begin
                    w_state_next = MEM_WAIT;
                end
            end
            default: begin
                w_mem_wait   = 1'b0;
                w_state_next = RUN;
            end
        endcase

        if (w_mem_wait) begin
            w_stall_fd = 1'b1;
            w_stall_em = 1'b1;
            w_flush_w  = 1'b1;
        end else if (i_branch_e) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (w_load_use) begin
            w_stall_fd = 1'b1;
            w_flush_e  = 1'b1;
        end else begin
            w_stall_fd = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Wait-cycle counter holds at the limit; the timeout flag is sticky until reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tcnt    <= {TCNT_W{1'b0}};
            r_timeout <= 1'b0;
        end else if (w_wait_tick) begin
            if (r_tcnt != TCNT_MAX) begin
                r_tcnt <= r_tcnt + TCNT_W'(1);
            end else begin
                r_tcnt <= r_tcnt;
            end
            if (r_tcnt >= TCNT_PRE) begin
                r_timeout <= 1'b1;
            end else begin
                r_timeout <= r_timeout;
            end
        end else begin
            r_tcnt    <= {TCNT_W{1'b0}};
            r_timeout <= r_timeout;
        end
    end

    // Saturating performance counters; branch flush implies case 2 won priority.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_count <= {CNT_W{1'b0}};
            r_flush_count <= {CNT_W{1'b0}};
        end else begin
            if (w_stall_fd && (r_stall_count != CNT_MAX)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end else begin
                r_stall_count <= r_stall_count;
            end
            if (w_flush_d && (r_flush_count != CNT_MAX)) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end else begin
                r_flush_count <= r_flush_count;
            end
        end
    end

    // Combinational controls are gated so that reset clears them without a clock.
    assign o_stall_f     = w_stall_fd & ~i_rst;
    assign o_stall_d     = w_stall_fd & ~i_rst;
    assign o_stall_e     = w_stall_em & ~i_rst;
    assign o_stall_m     = w_stall_em & ~i_rst;
    assign o_flush_d     = w_flush_d & ~i_rst;
    assign o_flush_e     = w_flush_e & ~i_rst;
    assign o_flush_w     = w_flush_w & ~i_rst;
    assign o_forward_a_e = i_rst ? FWD_RF : w_fwd_a;
    assign o_forward_b_e = i_rst ? FWD_RF : w_fwd_b;
    assign o_mem_timeout = r_timeout;
    assign o_stall_count = r_stall_count;
    assign o_flush_count = r_flush_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed vector table, multi-cycle sequences and random
// stimulus against a cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

    localparam int AW   = 5;
    localparam int CW   = 8;
    localparam int TO   = 4;
    localparam int CMAX = 255;

    logic clk = 1'b0;
    logic rst;
    logic branch_e, mem_read_e, reg_write_m, reg_write_w, mem_req_m, mem_ready_m;
    logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_timeout;
    logic [1:0] forward_a_e, forward_b_e;
    logic [CW-1:0] stall_count, flush_count;

    int n_checks = 0;
    int n_err    = 0;

    // Model state: "waiting on memory" flag, wait-cycle count, sticky timeout, event counts
    bit m_wait;
    int m_tcnt;
    bit m_tout;
    int m_sc;
    int m_fc;

    typedef struct {
        logic [1:0] fa, fb;
        logic sf, sd, se, sm, fd, fe, fw;
    } out_t;

    typedef struct {
        int br, rs1d, rs2d, rs1e, rs2e, rde, mre, rdm, wm, rdw, ww, req, rdy;
        int fa, fb, sf, fd, fe;
    } vec_t;

    vec_t tv[11];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_branch_e(branch_e),
        .i_rs1_d(rs1_d), .i_rs2_d(rs2_d), .i_rs1_e(rs1_e), .i_rs2_e(rs2_e),
        .i_rd_e(rd_e), .i_mem_read_e(mem_read_e),
        .i_rd_m(rd_m), .i_reg_write_m(reg_write_m),
        .i_rd_w(rd_w), .i_reg_write_w(reg_write_w),
        .i_mem_req_m(mem_req_m), .i_mem_ready_m(mem_ready_m),
        .o_stall_f(stall_f), .o_stall_d(stall_d), .o_stall_e(stall_e), .o_stall_m(stall_m),
        .o_flush_d(flush_d), .o_flush_e(flush_e), .o_flush_w(flush_w),
        .o_forward_a_e(forward_a_e), .o_forward_b_e(forward_b_e),
        .o_mem_timeout(mem_timeout), .o_stall_count(stall_count), .o_flush_count(flush_count)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [AW-1:0] rs);
        if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
        if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit waiting_now();
        if (m_wait) return !mem_ready_m;
        return mem_req_m && !mem_ready_m;
    endfunction

    function automatic out_t model_out();
        out_t o;
        bit lu;
        o = '{default: '0};
        lu = mem_read_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
        o.fa = ref_fwd(rs1_e);
        o.fb = ref_fwd(rs2_e);
        if (waiting_now()) begin
            o.sf = 1'b1; o.sd = 1'b1; o.se = 1'b1; o.sm = 1'b1; o.fw = 1'b1;
        end else if (branch_e) begin
            o.fd = 1'b1; o.fe = 1'b1;
        end else if (lu) begin
            o.sf = 1'b1; o.sd = 1'b1; o.fe = 1'b1;
        end
        return o;
    endfunction

    task automatic model_advance();
        out_t o;
        bit nxt;
        o = model_out();
        if (o.sf) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
        if (o.fd) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
        if (m_wait && !mem_ready_m) begin
            m_tcnt = (m_tcnt < TO) ? m_tcnt + 1 : TO;
            if (m_tcnt >= TO) m_tout = 1'b1;
        end
        nxt = waiting_now();
        if (!nxt) m_tcnt = 0;
        m_wait = nxt;
    endtask

    task automatic model_reset();
        m_wait = 0; m_tcnt = 0; m_tout = 0; m_sc = 0; m_fc = 0;
    endtask

    task automatic clear_inputs();
        branch_e = 0; mem_read_e = 0; reg_write_m = 0; reg_write_w = 0;
        mem_req_m = 0; mem_ready_m = 0;
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
    endtask

    // Called at a negedge with inputs driven; compares all outputs, then clocks the model
    task automatic cycle(input string tag);
        out_t e;
        e = model_out();
        #2;
        chk({tag, ".fwd_a"}, 32'(forward_a_e), 32'(e.fa));
        chk({tag, ".fwd_b"}, 32'(forward_b_e), 32'(e.fb));
        chk({tag, ".stall_f"}, 32'(stall_f), 32'(e.sf));
        chk({tag, ".stall_d"}, 32'(stall_d), 32'(e.sd));
        chk({tag, ".stall_e"}, 32'(stall_e), 32'(e.se));
        chk({tag, ".stall_m"}, 32'(stall_m), 32'(e.sm));
        chk({tag, ".flush_d"}, 32'(flush_d), 32'(e.fd));
        chk({tag, ".flush_e"}, 32'(flush_e), 32'(e.fe));
        chk({tag, ".flush_w"}, 32'(flush_w), 32'(e.fw));
        chk({tag, ".timeout"}, 32'(mem_timeout), 32'(m_tout));
        chk({tag, ".stall_cnt"}, 32'(stall_count), 32'(m_sc));
        chk({tag, ".flush_cnt"}, 32'(flush_count), 32'(m_fc));
        model_advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        clear_inputs();
        branch_e = v.br[0]; rs1_d = AW'(v.rs1d); rs2_d = AW'(v.rs2d);
        rs1_e = AW'(v.rs1e); rs2_e = AW'(v.rs2e); rd_e = AW'(v.rde); mem_read_e = v.mre[0];
        rd_m = AW'(v.rdm); reg_write_m = v.wm[0]; rd_w = AW'(v.rdw); reg_write_w = v.ww[0];
        mem_req_m = v.req[0]; mem_ready_m = v.rdy[0];
    endtask

    initial begin
        int base_sc, base_fc;
        // br rs1d rs2d rs1e rs2e rde mre rdm wm rdw ww req rdy | fa fb sf fd fe
        tv[0]  = '{0, 0, 0, 5, 0, 0, 0, 5, 1, 5, 1, 0, 0,  2, 0, 0, 0, 0};
        tv[1]  = '{0, 0, 0, 5, 0, 0, 0, 5, 0, 5, 1, 0, 0,  1, 0, 0, 0, 0};
        tv[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0};
        tv[3]  = '{0, 0, 0, 0, 9, 0, 0, 3, 1, 9, 1, 0, 0,  0, 1, 0, 0, 0};
        tv[4]  = '{0, 0, 0, 6, 6, 0, 0, 6, 1, 6, 1, 0, 0,  2, 2, 0, 0, 0};
        tv[5]  = '{0, 0, 7, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1};
        tv[6]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
        tv[7]  = '{1, 7, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1};
        tv[8]  = '{0, 0, 0, 4, 0, 0, 0, 4, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0};
        tv[9]  = '{0, 4, 5, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
        tv[10] = '{0, 7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};

        // Reset with inputs that would otherwise stall, flush and forward
        rst = 1'b1;
        clear_inputs();
        model_reset();
        mem_req_m = 1; branch_e = 1; rs1_e = 5'd5; rd_m = 5'd5; reg_write_m = 1;
        #1;
        chk("rst.stall_f", 32'(stall_f), 32'd0);
        chk("rst.stall_m", 32'(stall_m), 32'd0);
        chk("rst.flush_d", 32'(flush_d), 32'd0);
        chk("rst.flush_w", 32'(flush_w), 32'd0);
        chk("rst.fwd_a", 32'(forward_a_e), 32'd0);
        chk("rst.timeout", 32'(mem_timeout), 32'd0);
        chk("rst.stall_cnt", 32'(stall_count), 32'd0);
        chk("rst.flush_cnt", 32'(flush_count), 32'd0);
        do_reset();

        for (int i = 0; i < 11; i++) begin
            apply_vec(tv[i]);
            #1;
            chk($sformatf("vec%0d.fwd_a", i), 32'(forward_a_e), 32'(tv[i].fa));
            chk($sformatf("vec%0d.fwd_b", i), 32'(forward_b_e), 32'(tv[i].fb));
            chk($sformatf("vec%0d.stall_f", i), 32'(stall_f), 32'(tv[i].sf));
            chk($sformatf("vec%0d.flush_d", i), 32'(flush_d), 32'(tv[i].fd));
            chk($sformatf("vec%0d.flush_e", i), 32'(flush_e), 32'(tv[i].fe));
            cycle($sformatf("vec%0d", i));
        end

        // Load-use: one stall cycle, then the load in M forwards to E
        do_reset();
        mem_read_e = 1; rd_e = 5'd7; rs2_d = 5'd7;
        cycle("lu1");
        clear_inputs();
        rd_m = 5'd7; reg_write_m = 1; rs2_e = 5'd7;
        #1;
        chk("lu2.fwd_b", 32'(forward_b_e), 32'd2);
        chk("lu2.stall_f", 32'(stall_f), 32'd0);
        cycle("lu2");
        clear_inputs();
        #1;
        chk("lu3.stall_cnt", 32'(stall_count), 32'd1);
        cycle("lu3");

        // Memory wait for 3 cycles with branch_e held; branch handled on release only
        base_sc = m_sc;
        base_fc = m_fc;
        for (int k = 0; k < 3; k++) begin
            clear_inputs();
            mem_req_m = 1; branch_e = 1;
            #1;
            chk("mw.stall_m", 32'(stall_m), 32'd1);
            chk("mw.flush_w", 32'(flush_w), 32'd1);
            chk("mw.flush_d", 32'(flush_d), 32'd0);
            cycle($sformatf("mw%0d", k));
        end
        mem_ready_m = 1;
        #1;
        chk("mw.rel_stall_f", 32'(stall_f), 32'd0);
        chk("mw.rel_flush_d", 32'(flush_d), 32'd1);
        cycle("mw_rel");
        clear_inputs();
        #1;
        chk("mw.stall_cnt", 32'(stall_count), 32'(base_sc + 3));
        chk("mw.flush_cnt", 32'(flush_count), 32'(base_fc + 1));
        cycle("mw_after");

        // Timeout: ready low for 6 cycles; flag after the 4th counted wait cycle, sticky
        do_reset();
        for (int k = 0; k < 6; k++) begin
            mem_req_m = 1; mem_ready_m = 0;
            #1;
            chk($sformatf("to%0d.flag", k), 32'(mem_timeout), 32'(k == 5));
            cycle($sformatf("to%0d", k));
        end
        mem_ready_m = 1;
        cycle("to_rel");
        clear_inputs();
        cycle("to_idle0");
        #1;
        chk("to.sticky", 32'(mem_timeout), 32'd1);
        cycle("to_idle1");

        // Asynchronous reset between edges while in MEM_WAIT
        mem_req_m = 1; mem_ready_m = 0;
        cycle("ar0");
        cycle("ar1");
        #2;
        rst = 1'b1;
        #1;
        chk("ar.stall_f", 32'(stall_f), 32'd0);
        chk("ar.flush_w", 32'(flush_w), 32'd0);
        chk("ar.timeout", 32'(mem_timeout), 32'd0);
        chk("ar.stall_cnt", 32'(stall_count), 32'd0);
        model_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        #1;
        chk("ar.post_run", 32'(stall_f), 32'd0);
        cycle("ar_post");

        // Random stimulus against the model
        for (int n = 0; n < 400; n++) begin
            branch_e    = ($urandom_range(0, 5) == 0);
            mem_read_e  = $urandom_range(0, 1) == 1;
            reg_write_m = $urandom_range(0, 1) == 1;
            reg_write_w = $urandom_range(0, 1) == 1;
            mem_req_m   = ($urandom_range(0, 3) == 0);
            mem_ready_m = ($urandom_range(0, 2) != 0);
            rs1_d = AW'($urandom_range(0, 3)); rs2_d = AW'($urandom_range(0, 3));
            rs1_e = AW'($urandom_range(0, 3)); rs2_e = AW'($urandom_range(0, 3));
            rd_e  = AW'($urandom_range(0, 3)); rd_m  = AW'($urandom_range(0, 3));
            rd_w  = AW'($urandom_range(0, 3));
            cycle("rnd");
        end

        // Counter saturation
        do_reset();
        for (int n = 0; n < 260; n++) begin
            mem_req_m = 1; mem_ready_m = 0;
            cycle("sat_s");
        end
        mem_ready_m = 1;
        cycle("sat_rel");
        clear_inputs();
        for (int n = 0; n < 260; n++) begin
            branch_e = 1;
            cycle("sat_f");
        end
        clear_inputs();
        #1;
        chk("sat.stall_cnt", 32'(stall_count), 32'd255);
        chk("sat.flush_cnt", 32'(flush_count), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
